// File: rtl/fsm_mon_pkg.sv
// Shared constants and the arc-index helper for the FSM arc monitor and its benches.
package fsm_mon_pkg;

  localparam logic MON_EMPTY = 1'b0;
  localparam logic MON_TRACK = 1'b1;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  localparam int unsigned MAX_STATE_W = 3;

  // Arc index {from,to} for any state width up to MAX_STATE_W; callers truncate to 2*state_w.
  function automatic logic [2*MAX_STATE_W-1:0] arc_idx(input logic [MAX_STATE_W-1:0] from,
                                                       input logic [MAX_STATE_W-1:0] to,
                                                       input int unsigned state_w);
    logic [2*MAX_STATE_W-1:0] w_from;
    logic [2*MAX_STATE_W-1:0] w_to;
    w_from = {{MAX_STATE_W{1'b0}}, from};
    w_to   = {{MAX_STATE_W{1'b0}}, to};
    return (w_from << state_w) | w_to;
  endfunction

endpackage

// File: rtl/fsm_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module fsm_mon_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fsm_arc_monitor.sv
// Samples an FSM state vector, reports and counts state-to-state arcs against a legality mask.
// Optional macro FSM_ARC_MONITOR_SELFLOOP_EN: also report self-loop samples as arcs {s,s}.
module fsm_arc_monitor
  import fsm_mon_pkg::*;
#(
  parameter int unsigned                   STATE_W    = 1,
  parameter int unsigned                   CNT_W      = 8,
  parameter logic [(1<<(2*STATE_W))-1:0]   LEGAL_MASK = '1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_sample_en,
  input  logic [STATE_W-1:0]   i_state_in,
  input  logic                 i_clr,
  output logic                 o_arc_valid,
  output logic [STATE_W-1:0]   o_arc_from,
  output logic [STATE_W-1:0]   o_arc_to,
  output logic                 o_arc_illegal,
  output logic [CNT_W-1:0]     o_illegal_cnt,
  input  logic [2*STATE_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0]     o_rd_cnt
);

  localparam int unsigned IDX_W    = 2 * STATE_W;
  localparam int unsigned NUM_ARCS = 1 << IDX_W;

  logic               r_state;
  logic               w_state_next;
  logic [STATE_W-1:0] r_prev;
  logic [STATE_W-1:0] w_prev_next;
  logic               w_arc_det;

  logic               r_pend;
  logic [STATE_W-1:0] r_pend_from;
  logic [STATE_W-1:0] r_pend_to;
  logic [IDX_W-1:0]   w_pend_idx;
  logic               w_pend_illegal;

  logic               r_arc_valid;
  logic               r_arc_illegal;
  logic [STATE_W-1:0] r_arc_from;
  logic [STATE_W-1:0] r_arc_to;
  logic [CNT_W-1:0]   r_rd_cnt;

  logic [NUM_ARCS-1:0] w_cnt_inc;
  logic                w_ill_inc;
  logic [CNT_W-1:0]    w_cnt [NUM_ARCS];

  // Control FSM state register
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= MON_EMPTY;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_next;
      r_prev  <= w_prev_next;
    end
  end

  // Next state: clr wins over a simultaneous sample, which is then discarded
  always_comb begin
    w_state_next = r_state;
    w_prev_next  = r_prev;
    if (i_clr) begin
      w_state_next = MON_EMPTY;
      w_prev_next  = '0;
    end else if (i_sample_en) begin
      w_state_next = MON_TRACK;
      w_prev_next  = i_state_in;
    end
  end

  // Arc detection and per-arc increment decode
  always_comb begin
`ifdef FSM_ARC_MONITOR_SELFLOOP_EN
    w_arc_det = i_sample_en && !i_clr && (r_state == MON_TRACK);
`else
    w_arc_det = i_sample_en && !i_clr && (r_state == MON_TRACK) && (i_state_in != r_prev);
`endif
    w_pend_idx     = IDX_W'(arc_idx(3'(r_pend_from), 3'(r_pend_to), STATE_W));
    w_pend_illegal = ~LEGAL_MASK[w_pend_idx];
    w_ill_inc      = r_pend && !i_clr && w_pend_illegal;
    w_cnt_inc      = '0;
    for (int k = 0; k < NUM_ARCS; k++) begin
      w_cnt_inc[k] = r_pend && !i_clr && (w_pend_idx == IDX_W'(k));
    end
  end

  // Detected arc waits one cycle in the pending stage before being reported and counted
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_pend        <= 1'b0;
      r_pend_from   <= '0;
      r_pend_to     <= '0;
      r_arc_valid   <= 1'b0;
      r_arc_illegal <= 1'b0;
      r_arc_from    <= '0;
      r_arc_to      <= '0;
      r_rd_cnt      <= '0;
    end else begin
      r_pend <= w_arc_det;
      if (w_arc_det) begin
        r_pend_from <= r_prev;
        r_pend_to   <= i_state_in;
      end
      r_arc_valid   <= r_pend;
      r_arc_illegal <= r_pend && w_pend_illegal;
      if (r_pend) begin
        r_arc_from <= r_pend_from;
        r_arc_to   <= r_pend_to;
      end
      r_rd_cnt <= w_cnt[i_rd_idx];
    end
  end

  for (genvar g = 0; g < NUM_ARCS; g++) begin : g_arc_cnt
    fsm_mon_sat_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_inc     (w_cnt_inc[g]),
      .i_clr     (i_clr),
      .o_cnt     (w_cnt[g])
    );
  end

  fsm_mon_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_ill_cnt (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_inc     (w_ill_inc),
    .i_clr     (i_clr),
    .o_cnt     (o_illegal_cnt)
  );

  assign o_arc_valid   = r_arc_valid;
  assign o_arc_illegal = r_arc_illegal;
  assign o_arc_from    = r_arc_from;
  assign o_arc_to      = r_arc_to;
  assign o_rd_cnt      = r_rd_cnt;

endmodule

// File: tb/tb_fsm_arc_monitor.sv
// Directed, table-driven bench for fsm_arc_monitor (STATE_W=1, CNT_W=8).
module tb_fsm_arc_monitor;
  import fsm_mon_pkg::*;

`ifdef FSM_ARC_MONITOR_SELFLOOP_EN
  localparam int EXP_SL = 4;
`else
  localparam int EXP_SL = 0;
`endif

  typedef struct {
    logic       en;
    logic       st;
    logic       clr;
    logic [1:0] rd;
    logic       ev;
    logic       ef;
    logic       et;
    logic       ei;
    logic [7:0] eic;
    logic [7:0] erc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_en, a_st, a_clr;
  logic [1:0] a_rd;
  logic       a_valid, a_from, a_to, a_ill;
  logic [7:0] a_icnt, a_rcnt;
  logic       b_en, b_st, b_clr;
  logic [1:0] b_rd;
  logic       b_valid, b_from, b_to, b_ill;
  logic [7:0] b_icnt, b_rcnt;

  int checks   = 0;
  int failures = 0;

  vec_t vec1 [9];
  vec_t vclr [8];

  always #5 clk = ~clk;

  fsm_arc_monitor #(.STATE_W(1), .CNT_W(8), .LEGAL_MASK(4'b0110)) u_dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_sample_en(a_en), .i_state_in(a_st), .i_clr(a_clr),
    .o_arc_valid(a_valid), .o_arc_from(a_from), .o_arc_to(a_to), .o_arc_illegal(a_ill),
    .o_illegal_cnt(a_icnt), .i_rd_idx(a_rd), .o_rd_cnt(a_rcnt)
  );

  fsm_arc_monitor #(.STATE_W(1), .CNT_W(8), .LEGAL_MASK(4'b0010)) u_dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_sample_en(b_en), .i_state_in(b_st), .i_clr(b_clr),
    .o_arc_valid(b_valid), .o_arc_from(b_from), .o_arc_to(b_to), .o_arc_illegal(b_ill),
    .o_illegal_cnt(b_icnt), .i_rd_idx(b_rd), .o_rd_cnt(b_rcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int en, input int st, input int clr, input int rd,
                              input int ev, input int ef, input int et, input int ei,
                              input int eic, input int erc);
    vec_t v;
    v.en = 1'(en); v.st = 1'(st); v.clr = 1'(clr); v.rd = 2'(rd);
    v.ev = 1'(ev); v.ef = 1'(ef); v.et = 1'(et); v.ei = 1'(ei);
    v.eic = 8'(eic); v.erc = 8'(erc);
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    a_en = v.en; a_st = v.st; a_clr = v.clr; a_rd = v.rd;
    tick();
    chk({tag, " valid"},   int'(a_valid), int'(v.ev));
    chk({tag, " from"},    int'(a_from),  int'(v.ef));
    chk({tag, " to"},      int'(a_to),    int'(v.et));
    chk({tag, " illegal"}, int'(a_ill),   int'(v.ei));
    chk({tag, " ill_cnt"}, int'(a_icnt),  int'(v.eic));
    chk({tag, " rd_cnt"},  int'(a_rcnt),  int'(v.erc));
  endtask

  initial begin
    int npulse;
    int nill;
    //               en st clr rd  ev ef et ei ic rc
    vec1[0] = mk(1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    vec1[1] = mk(1, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    vec1[2] = mk(1, 0, 0, 1,  1, 0, 1, 0, 0, 0);  // rd shows pre-increment value
    vec1[3] = mk(0, 0, 0, 1,  1, 1, 0, 0, 0, 1);
    vec1[4] = mk(0, 0, 0, 2,  0, 1, 0, 0, 0, 1);
    vec1[5] = mk(0, 1, 0, 2,  0, 1, 0, 0, 0, 1);  // disabled sample ignored
    vec1[6] = mk(1, 1, 0, 1,  0, 1, 0, 0, 0, 1);
    vec1[7] = mk(0, 0, 0, 1,  1, 0, 1, 0, 0, 1);
    vec1[8] = mk(0, 0, 0, 1,  0, 0, 1, 0, 0, 2);

    vclr[0] = mk(1, 0, 0, 2,  0, 0, 1, 0, 0, 255);
    vclr[1] = mk(1, 1, 1, 2,  1, 1, 0, 0, 0, 255);  // pending arc still emitted
    vclr[2] = mk(0, 0, 0, 2,  0, 1, 0, 0, 0, 0);
    vclr[3] = mk(1, 0, 0, 1,  0, 1, 0, 0, 0, 0);
    vclr[4] = mk(0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
    vclr[5] = mk(1, 1, 0, 1,  0, 1, 0, 0, 0, 0);
    vclr[6] = mk(0, 1, 0, 1,  1, 0, 1, 0, 0, 0);
    vclr[7] = mk(0, 1, 0, 1,  0, 0, 1, 0, 0, 1);

    rst_n = 1'b0;
    a_en = 1'b0; a_st = ZERO; a_clr = 1'b0; a_rd = 2'b00;
    b_en = 1'b0; b_st = ZERO; b_clr = 1'b0; b_rd = 2'b00;
    tick();
    tick();
    chk("reset valid",   int'(a_valid), 0);
    chk("reset from",    int'(a_from),  0);
    chk("reset to",      int'(a_to),    0);
    chk("reset illegal", int'(a_ill),   0);
    chk("reset ill_cnt", int'(a_icnt),  0);
    chk("reset rd_cnt",  int'(a_rcnt),  0);
    rst_n = 1'b1;

    // Only 0->1 legal on B: samples 0,1,0
    b_en = 1'b1; b_st = ZERO; tick();
    b_st = ONE; tick();
    b_st = ZERO; tick();
    chk("maskB arc1 valid",   int'(b_valid), 1);
    chk("maskB arc1 illegal", int'(b_ill),   0);
    b_en = 1'b0; tick();
    chk("maskB arc2 valid",   int'(b_valid), 1);
    chk("maskB arc2 from",    int'(b_from),  1);
    chk("maskB arc2 to",      int'(b_to),    0);
    chk("maskB arc2 illegal", int'(b_ill),   1);
    chk("maskB arc2 ill_cnt", int'(b_icnt),  1);
    tick();
    chk("maskB idle illegal", int'(b_ill),   0);
    chk("maskB idle ill_cnt", int'(b_icnt),  1);

    for (int i = 0; i < 9; i++) apply(vec1[i], $sformatf("basic[%0d]", i));

    // Alternate 0/1 long enough to saturate both legal arcs
    for (int i = 0; i < 600; i++) begin
      a_en = 1'b1; a_st = 1'(i % 2); tick();
    end
    a_en = 1'b0; tick();
    a_rd = 2'b01; tick();
    chk("sat rd01", int'(a_rcnt), 255);
    a_rd = 2'b10; tick();
    chk("sat rd10", int'(a_rcnt), 255);
    chk("sat ill_cnt", int'(a_icnt), 0);

    for (int i = 0; i < 8; i++) apply(vclr[i], $sformatf("clr[%0d]", i));

    // Reset mid-stream with an arc pending and counters non-zero
    a_en = 1'b1; a_st = ZERO; tick();
    chk("rst pre valid", int'(a_valid), 0);
    rst_n = 1'b0; a_st = ONE; tick();
    chk("rst mid valid",   int'(a_valid), 0);
    chk("rst mid from",    int'(a_from),  0);
    chk("rst mid to",      int'(a_to),    0);
    chk("rst mid rd_cnt",  int'(a_rcnt),  0);
    chk("rst mid B ill_cnt", int'(b_icnt), 0);
    rst_n = 1'b1; a_st = ZERO; a_rd = 2'b01; tick();
    chk("rst post valid",  int'(a_valid), 0);
    chk("rst post rd01",   int'(a_rcnt),  0);
    a_st = ONE; tick();
    chk("rst first sample no arc", int'(a_valid), 0);
    a_en = 1'b0; tick();
    chk("rst resume valid", int'(a_valid), 1);
    chk("rst resume from",  int'(a_from),  0);
    chk("rst resume to",    int'(a_to),    1);

    // Hold state 0 for five samples from EMPTY
    a_clr = 1'b1; tick();
    a_clr = 1'b0;
    npulse = 0;
    nill = 0;
    for (int i = 0; i < 7; i++) begin
      a_en = (i < 5); a_st = ZERO; tick();
      if (a_valid) npulse++;
      if (a_ill) nill++;
    end
    a_rd = 2'b00; tick();
    chk("selfloop pulses",   npulse,         EXP_SL);
    chk("selfloop illegal",  nill,           EXP_SL);
    chk("selfloop cnt00",    int'(a_rcnt),   EXP_SL);
    chk("selfloop ill_cnt",  int'(a_icnt),   EXP_SL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
